mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_pkg.sv | 17 +
 rtl/mul_div_datapath.sv | 96 +++++++++
 rtl/mul_div_unit.sv | 90 +++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared encodings and default widths for the iterative multiply/divide unit.
// Optional signed support in the unit is enabled by defining SIGNED_OPS_EN.
package mul_div_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int REG_ADDR_W_DEF = 3;

    localparam logic [1:0] OP_MUL_LO = 2'b00;
    localparam logic [1:0] OP_MUL_HI = 2'b01;
    localparam logic [1:0] OP_DIV    = 2'b10;
    localparam logic [1:0] OP_REM    = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul_div_datapath.sv
// Shift-add multiplier / restoring divider sharing one hi:lo register pair.
// Operates on magnitudes; sign correction is applied in the final result mux.
module mul_div_datapath
    import mul_div_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [1:0]        op,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] final_result
);

    logic [DATA_W-1:0] hi, lo, opnd, dividend_q;
    logic [DATA_W-1:0] hi_n, lo_n, mag_a, mag_b;
    logic [DATA_W:0]   sum, rem_try;
    logic [1:0]        op_q;
    logic              neg_q, rem_neg_q, div_zero_q;

    assign mag_a = (signed_op && a[DATA_W-1]) ? -a : a;
    assign mag_b = (signed_op && b[DATA_W-1]) ? -b : b;

    // MUL: lo holds the multiplier and shifts right as the product fills hi:lo.
    // DIV: lo holds the dividend shifting left into hi, quotient bits enter lo[0].
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        hi_n    = hi;
        lo_n    = lo;
        sum     = '0;
        rem_try = '0;
        if (op_q[1]) begin
            rem_try = {hi, lo[DATA_W-1]};
            if (rem_try >= {1'b0, opnd}) begin
                hi_n = rem_try[DATA_W-1:0] - opnd;
                lo_n = {lo[DATA_W-2:0], 1'b1};
            end else begin
                hi_n = rem_try[DATA_W-1:0];
                lo_n = {lo[DATA_W-2:0], 1'b0};
            end
        end else begin
            sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
            hi_n = sum[DATA_W:1];
            lo_n = {sum[0], lo[DATA_W-1:1]};
        end
    end

    // Result is formed from the post-step values so it is ready on the final step edge.
    always_comb begin
        logic [2*DATA_W-1:0] prod;
        logic [DATA_W-1:0]   quo, rem;
        prod = {hi_n, lo_n};
        if (neg_q) prod = -prod;
        quo = neg_q ? -lo_n : lo_n;
        rem = rem_neg_q ? -hi_n : hi_n;
        final_result = '0;
        case (op_q)
            OP_MUL_LO: final_result = prod[DATA_W-1:0];
            OP_MUL_HI: final_result = prod[2*DATA_W-1:DATA_W];
            OP_DIV:    final_result = div_zero_q ? '1 : quo;
            OP_REM:    final_result = div_zero_q ? dividend_q : rem;
            default:   final_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            dividend_q <= '0;
            op_q       <= OP_MUL_LO;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (load) begin
            hi         <= '0;
            lo         <= mag_a;
            opnd       <= mag_b;
            dividend_q <= a;
            op_q       <= op;
            neg_q      <= signed_op && (a[DATA_W-1] ^ b[DATA_W-1]);
            rem_neg_q  <= signed_op && a[DATA_W-1];
            div_zero_q <= (b == '0);
        end else if (step) begin
            hi <= hi_n;
            lo <= lo_n;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/DIV/REM unit with register-file write-back handshake.
// Define SIGNED_OPS_EN to add the Signed_op input for two's-complement operation.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [1:0]            Op,
`ifdef SIGNED_OPS_EN
    input  logic                  Signed_op,
`endif
    input  logic [DATA_W-1:0]     Operand_a,
    input  logic [DATA_W-1:0]     Operand_b,
    input  logic [REG_ADDR_W-1:0] Dest_reg_num,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_W-1:0]     Result,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Write_reg_num
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [DATA_W-1:0]     final_result;
    logic                  signed_sel, load, step, last_step;

`ifdef SIGNED_OPS_EN
    assign signed_sel = Signed_op;
`else
    assign signed_sel = 1'b0;
`endif

    assign load      = (state == ST_IDLE) && Start;
    assign step      = (state == ST_RUN);
    assign last_step = step && (cnt == CNT_W'(DATA_W - 1));
    assign Busy      = (state != ST_IDLE);
    assign Done      = (state == ST_DONE);
    assign RegWrite  = Done;

    mul_div_datapath #(.DATA_W(DATA_W)) u_datapath (
        .clk          (clk),
        .rst_n        (Reset),
        .load         (load),
        .step         (step),
        .op           (Op),
        .signed_op    (signed_sel),
        .a            (Operand_a),
        .b            (Operand_b),
        .final_result (final_result)
    );

    // Result/Write_reg_num are loaded only on the last RUN step and hold until the next completion.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            dest_q        <= '0;
            Result        <= '0;
            Write_reg_num <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        dest_q <= Dest_reg_num;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        Result        <= final_result;
                        Write_reg_num <= dest_q;
                        state         <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expectations, a monitor checks each Done.
// Signed vectors are exercised when SIGNED_OPS_EN is defined.
module tb_mul_div_unit;
    import mul_div_pkg::*;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef struct {
        logic [DW-1:0] res;
        logic [AW-1:0] dst;
        int            acc;
        string         name;
    } exp_t;

    logic          clk;
    logic          Reset;
    logic          Start;
    logic [1:0]    Op;
    logic [DW-1:0] Operand_a, Operand_b;
    logic [AW-1:0] Dest_reg_num;
    logic          Busy, Done, RegWrite;
    logic [DW-1:0] Result;
    logic [AW-1:0] Write_reg_num;
`ifdef SIGNED_OPS_EN
    logic          signed_op;
`endif

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;
    logic [DW-1:0] last_res = '0;
    logic [AW-1:0] last_wr = '0;
    logic          prev_done = 1'b0;

    mul_div_unit #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Start         (Start),
        .Op            (Op),
`ifdef SIGNED_OPS_EN
        .Signed_op     (signed_op),
`endif
        .Operand_a     (Operand_a),
        .Operand_b     (Operand_b),
        .Dest_reg_num  (Dest_reg_num),
        .Busy          (Busy),
        .Done          (Done),
        .Result        (Result),
        .RegWrite      (RegWrite),
        .Write_reg_num (Write_reg_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; the following posedge accepts the request.
    task automatic launch(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [AW-1:0] dst, input logic [DW-1:0] res);
        exp_t e;
        Op = op; Operand_a = a; Operand_b = b; Dest_reg_num = dst; Start = 1'b1;
        e.res = res; e.dst = dst; e.acc = edge_cnt + 1; e.name = name;
        q.push_back(e);
        @(posedge clk); #1;
        Start = 1'b0;
        check({name, "_busy"}, 32'(Busy), 32'd1);
        // Scramble inputs: the captured operands must not follow them.
        Operand_a = ~a; Operand_b = ~b; Dest_reg_num = ~dst; Op = ~op;
    endtask

    task automatic issue(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [AW-1:0] dst, input logic [DW-1:0] res);
        int n = 0;
        @(negedge clk);
        while (Busy && n < 40) begin @(negedge clk); n++; end
        if (Busy) check({name, "_idle_timeout"}, 32'(Busy), 32'd0);
        launch(name, op, a, b, dst, res);
    endtask

    // Monitor: Done must match the scoreboard head, 9 posedges counting the accepting edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (!Reset) begin
                prev_done = 1'b0;
            end else begin
                check("regwrite_eq_done", 32'(RegWrite), 32'(Done));
                if (Done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'(Done), 32'd0);
                    end else begin
                        e = q.pop_front();
                        check({e.name, "_result"}, 32'(Result), 32'(e.res));
                        check({e.name, "_wr_num"}, 32'(Write_reg_num), 32'(e.dst));
                        check({e.name, "_latency"}, 32'(edge_cnt - e.acc), 32'(DW));
                        last_res = e.res;
                        last_wr  = e.dst;
                    end
                end else if (prev_done) begin
                    check("hold_result", 32'(Result), 32'(last_res));
                    check("hold_wr_num", 32'(Write_reg_num), 32'(last_wr));
                end
                prev_done = Done;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        Reset = 1'b0; Start = 1'b0; Op = '0; Operand_a = '0; Operand_b = '0; Dest_reg_num = '0;
`ifdef SIGNED_OPS_EN
        signed_op = 1'b0;
`endif
        #12;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_result", 32'(Result), 32'd0);
        @(negedge clk); Reset = 1'b1;

        issue("mul_13x11",   OP_MUL_LO, 8'd13,  8'd11,  3'd1, 8'h8F);
        issue("mulhi_200sq", OP_MUL_HI, 8'd200, 8'd200, 3'd2, 8'h9C);
        issue("mullo_200sq", OP_MUL_LO, 8'd200, 8'd200, 3'd3, 8'h40);
        issue("div_100_7",   OP_DIV,    8'd100, 8'd7,   3'd5, 8'd14);
        issue("rem_100_7",   OP_REM,    8'd100, 8'd7,   3'd5, 8'd2);
        issue("div_by_zero", OP_DIV,    8'h5A,  8'h00,  3'd6, 8'hFF);
        issue("rem_by_zero", OP_REM,    8'h5A,  8'h00,  3'd0, 8'h5A);
        issue("mulhi_ff_ff", OP_MUL_HI, 8'hFF,  8'hFF,  3'd7, 8'hFE);
        issue("rem_255_16",  OP_REM,    8'hFF,  8'h10,  3'd4, 8'h0F);

        // A second Start mid-RUN must be ignored.
        issue("mid_start", OP_MUL_LO, 8'd7, 8'd9, 3'd2, 8'd63);
        repeat (3) @(negedge clk);
        Op = OP_DIV; Operand_a = 8'd1; Operand_b = 8'd1; Dest_reg_num = 3'd7; Start = 1'b1;
        @(negedge clk); Start = 1'b0;

`ifdef SIGNED_OPS_EN
        signed_op = 1'b1;
        issue("sdiv_min_m1", OP_DIV, 8'h80, 8'hFF, 3'd1, 8'h80);
        issue("srem_min_m1", OP_REM, 8'h80, 8'hFF, 3'd1, 8'h00);
        issue("sdiv_m7_2",   OP_DIV, 8'hF9, 8'h02, 3'd2, 8'hFD);
        issue("srem_m7_2",   OP_REM, 8'hF9, 8'h02, 3'd2, 8'hFF);
        issue("sdiv_zero",   OP_DIV, 8'hF9, 8'h00, 3'd3, 8'hFF);
        issue("smul_m3_5",   OP_MUL_HI, 8'hFD, 8'h05, 3'd3, 8'hFF);
        @(negedge clk);
        while (Busy) @(negedge clk);
        signed_op = 1'b0;
`else
        issue("udiv_80_ff", OP_DIV, 8'h80, 8'hFF, 3'd1, 8'h00);
        issue("urem_80_ff", OP_REM, 8'h80, 8'hFF, 3'd1, 8'h80);
`endif

        // Reset during RUN aborts the operation with no later write-back.
        issue("rst_abort", OP_MUL_LO, 8'd13, 8'd11, 3'd3, 8'h8F);
        repeat (3) @(posedge clk);
        #2;
        Reset = 1'b0;
        q.delete();
        last_res = '0; last_wr = '0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_regwrite", 32'(RegWrite), 32'd0);
        check("abort_result", 32'(Result), 32'd0);
        check("abort_wr_num", 32'(Write_reg_num), 32'd0);
        @(negedge clk); Reset = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_writeback", 32'(Busy), 32'd0);

        // Start is accepted on the first posedge after reset release.
        Reset = 1'b0;
        @(negedge clk);
        Reset = 1'b1;
        launch("first_edge", OP_MUL_HI, 8'd16, 8'd32, 3'd6, 8'h02);

        n = 0;
        while (q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
